// File: rtl/core_config_pkg.sv
// core_config_pkg: shared widths, opcode/unit/state enums, slot record and opcode classification helpers.
package core_config_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
    OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_LW, OP_LB, OP_SW, OP_SB,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL, OP_JALR,
    OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_CSRRW, OP_CSRRS, OP_CSRRC
  } opcodes_t;
  typedef enum logic [1:0] {UNIT_ALU, UNIT_MDU, UNIT_LSU, UNIT_BRU} units_t;
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TRAP} sched_state_t;
  typedef struct packed {
    opcodes_t opcode;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] address;
    logic illegal;
  } slot_t;
  function automatic units_t op_unit(input opcodes_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU} ? UNIT_MDU :
           op inside {OP_LW, OP_LB, OP_SW, OP_SB} ? UNIT_LSU :
           op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL, OP_JALR} ? UNIT_BRU : UNIT_ALU;
  endfunction
  function automatic logic is_serializing(input opcodes_t op);
    return op inside {OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_CSRRW, OP_CSRRS, OP_CSRRC};
  endfunction
  function automatic logic uses_rs1(input opcodes_t op);
    return !(op inside {OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET});
  endfunction
  function automatic logic uses_rs2(input opcodes_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
                      OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_SW, OP_SB,
                      OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
  endfunction
  function automatic logic writes_rd(input opcodes_t op);
    return !(op inside {OP_NOP, OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
                        OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET});
  endfunction
endpackage

// File: rtl/scoreboard.sv
// scoreboard: per-register pending-write bits; ports: set (issue), NUM_WB clear (writeback), flush, busy vector, all_clear.
module scoreboard
  import core_config_pkg::*;
#(
  parameter int NUM_WB = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clk_en,
  input  logic                                 flush,
  input  logic                                 set_valid,
  input  logic [REG_ADDR_W-1:0]                set_idx,
  input  logic [NUM_WB-1:0]                    clr_valid,
  input  logic [NUM_WB-1:0][REG_ADDR_W-1:0]    clr_idx,
  output logic [NUM_REGS-1:0]                  busy,
  output logic                                 all_clear
);
  logic [NUM_REGS-1:0] busy_d;
  // Set is applied after the clears so a same-cycle issue keeps its bit.
  always_comb begin
    busy_d = busy;
    for (int k = 0; k < NUM_WB; k++) if (clr_valid[k]) busy_d[clr_idx[k]] = 1'b0;
    if (set_valid) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else if (clk_en) busy <= flush ? '0 : busy_d;
  assign all_clear = ~|busy;
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: single-slot in-order issue with scoreboard hazards, serializing drain and illegal-op trap; ports: dec_* in, iss_* out, unit busys, writebacks, flush, trap.
module issue_scheduler
  import core_config_pkg::*;
#(
  parameter int NUM_WB = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clk_en,
  input  logic                              dec_valid,
  input  opcodes_t                          dec_opcode,
  input  logic [REG_ADDR_W-1:0]             dec_rs1,
  input  logic [REG_ADDR_W-1:0]             dec_rs2,
  input  logic [REG_ADDR_W-1:0]             dec_rd,
  input  logic [XLEN-1:0]                   dec_imm,
  input  logic [XLEN-1:0]                   dec_address,
  input  logic                              dec_illegal,
  output logic                              o_busy,
  input  logic                              alu_busy,
  input  logic                              mdu_busy,
  input  logic                              lsu_busy,
  input  logic                              bru_busy,
  output logic                              iss_valid,
  output units_t                            iss_unit,
  output opcodes_t                          iss_opcode,
  output logic [REG_ADDR_W-1:0]             iss_rs1,
  output logic [REG_ADDR_W-1:0]             iss_rs2,
  output logic [REG_ADDR_W-1:0]             iss_rd,
  output logic [XLEN-1:0]                   iss_imm,
  output logic [XLEN-1:0]                   iss_address,
  input  logic [NUM_WB-1:0]                 wb_valid,
  input  logic [NUM_WB-1:0][REG_ADDR_W-1:0] wb_rd,
  input  logic                              flush,
  output logic                              trap,
  output logic [XLEN-1:0]                   trap_address
);
  slot_t               slot_q;
  logic                slot_valid_q;
  sched_state_t        state_q, state_d;
  logic [NUM_REGS-1:0] sb_busy;
  logic                sb_all_clear, sb_set;
  units_t              unit;
  logic                unit_busy, hazard, serial, fire, nop_consume, take_trap, load;
  scoreboard #(.NUM_WB(NUM_WB)) u_sb (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .set_valid(sb_set), .set_idx(slot_q.rd),
    .clr_valid(wb_valid), .clr_idx(wb_rd),
    .busy(sb_busy), .all_clear(sb_all_clear)
  );
  // Serializing ops only fire from DRAIN, and only once the whole machine is quiet.
  always_comb begin
    unit = op_unit(slot_q.opcode);
    unit_busy = unit == UNIT_MDU ? mdu_busy : unit == UNIT_LSU ? lsu_busy :
                unit == UNIT_BRU ? bru_busy : alu_busy;
    hazard = (uses_rs1(slot_q.opcode) && sb_busy[slot_q.rs1]) ||
             (uses_rs2(slot_q.opcode) && sb_busy[slot_q.rs2]) ||
             (writes_rd(slot_q.opcode) && sb_busy[slot_q.rd]);
    serial = is_serializing(slot_q.opcode);
    fire = slot_valid_q && !slot_q.illegal && slot_q.opcode != OP_NOP && !hazard && !unit_busy &&
           (serial ? state_q == S_DRAIN && sb_all_clear && !(alu_busy || mdu_busy || lsu_busy || bru_busy)
                   : state_q == S_RUN);
    nop_consume = slot_valid_q && state_q == S_RUN && !slot_q.illegal && slot_q.opcode == OP_NOP;
    take_trap = slot_valid_q && state_q == S_RUN && slot_q.illegal;
    load = dec_valid && state_q == S_RUN && (!slot_valid_q || fire || nop_consume);
    o_busy = (slot_valid_q && !(fire || nop_consume)) || state_q != S_RUN;
    sb_set = fire && !flush && writes_rd(slot_q.opcode) && slot_q.rd != '0;
    state_d = state_q == S_RUN ? (take_trap ? S_TRAP : slot_valid_q && serial ? S_DRAIN : S_RUN) :
              state_q == S_DRAIN ? (fire ? S_RUN : S_DRAIN) : S_TRAP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      iss_valid    <= 1'b0;
      iss_unit     <= UNIT_ALU;
      iss_opcode   <= OP_NOP;
      iss_rs1      <= '0;
      iss_rs2      <= '0;
      iss_rd       <= '0;
      iss_imm      <= '0;
      iss_address  <= '0;
      trap         <= 1'b0;
      trap_address <= '0;
    end else if (!clk_en) begin
      iss_valid <= 1'b0;
      trap      <= 1'b0;
    end else begin
      state_q      <= flush ? S_RUN : state_d;
      slot_valid_q <= !flush && (load || (slot_valid_q && !(fire || nop_consume || take_trap)));
      if (load) slot_q <= '{opcode: dec_opcode, rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                            imm: dec_imm, address: dec_address, illegal: dec_illegal};
      iss_valid <= fire && !flush;
      trap      <= take_trap && !flush;
      if (fire && !flush) begin
        iss_unit    <= unit;
        iss_opcode  <= slot_q.opcode;
        iss_rs1     <= slot_q.rs1;
        iss_rs2     <= slot_q.rs2;
        iss_rd      <= slot_q.rd;
        iss_imm     <= slot_q.imm;
        iss_address <= slot_q.address;
      end
      if (take_trap && !flush) trap_address <= slot_q.address;
    end
  end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_WB, default 2, meaning number of writeback ports that clear scoreboard bits.
REQ-002 SHALL have ports (one per line):
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, active-low.
- clk_en  in  1  global clock enable; when low, all state holds.
- dec_valid  in  1  decoder output carries an instruction.
- dec_opcode  in  opcodes_t  decoded operation.
- dec_rs1, dec_rs2, dec_rd  in  REG_ADDR_W each  register indices.
- dec_imm, dec_address  in  XLEN each  immediate, instruction address.
- dec_illegal  in  1  decoder illegal flag.
- o_busy  out  1  stall to decoder; decoder holds its outputs while high.
- alu_busy, mdu_busy, lsu_busy, bru_busy  in  1 each  unit cannot accept.
- iss_valid  out  1  issue strobe, one cycle per instruction.
- iss_unit  out  units_t  target unit.
- iss_opcode, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_address  out  same widths as dec_*.
- wb_valid  in  NUM_WB  writeback port strobes.
- wb_rd  in  NUM_WB x REG_ADDR_W  writeback destinations.
- flush  in  1  pipeline flush (branch redirect/trap return).
- trap  out  1  illegal-instruction trap pulse.
- trap_address  out  XLEN  address of the illegal instruction.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low; ports named clk and rst_n.

Function
REQ-004 SHALL hold one instruction in a slot register; slot loads from dec_* when dec_valid, slot empty or slot issuing this cycle, and state RUN.
REQ-005 o_busy SHALL be high whenever slot is full and not issuing this cycle, or state is not RUN.
REQ-006 Scoreboard: 32 busy bits; bit 0 never set; issue of an instruction with rd != 0 that writes rd sets bit rd.
REQ-007 wb_valid[k] SHALL clear bit wb_rd[k] at cycle end; when issue sets and writeback clears the same bit in one cycle, set wins.
REQ-008 Hazard check SHALL use registered scoreboard only (no bypass): slot issues earliest the cycle after the clearing writeback.
REQ-009 Slot SHALL issue when: valid, rs1 and rs2 (those the opcode uses) not busy, rd not busy (WAW), target unit busy low.
REQ-010 Unit mapping: MUL/DIV/REM group -> MDU; loads/stores -> LSU; branches, JAL, JALR -> BRU; all others -> ALU.
REQ-011 iss_* SHALL be registered; iss_valid high exactly one cycle per issued instruction; latency dec accept -> iss_valid minimum 2 cycles.
REQ-012 States: RUN, DRAIN, TRAP. FENCE, ECALL, EBREAK, MRET, CSR* in slot move RUN -> DRAIN; issue only after scoreboard all-clear and all unit busy low; then return to RUN.
REQ-013 dec_illegal accepted into slot SHALL not issue: trap pulses one cycle with trap_address = slot address; state -> TRAP; o_busy high until flush.
REQ-014 flush SHALL in the same edge empty slot, clear all scoreboard bits, force RUN, suppress iss_valid and trap that cycle; flush wins over every simultaneous event.
REQ-015 NOP opcode SHALL be consumed without issue and without scoreboard change.
REQ-016 clk_en low SHALL freeze slot, scoreboard, state and outputs; iss_valid and trap forced low.

Reset
REQ-017 Reset SHALL yield: slot empty, scoreboard all zero, state RUN, iss_valid 0, trap 0, o_busy 0, all iss_* and trap_address zero, iss_unit ALU.
REQ-018 Reset asserted mid-DRAIN or mid-TRAP SHALL return to RUN without emitting any issue or trap.

Structure
REQ-019 units_t (ALU, MDU, LSU, BRU) and sched_state_t SHALL live in core_config_pkg, with an opcode-to-unit function and an is_serializing function.
REQ-020 Scoreboard SHALL be a sub-module named scoreboard (set port, NUM_WB clear ports, all-clear output).

Verification
REQ-021 ADD x5 then ADD x6,x5,x1, wb x5 3 cycles after first issue -> second iss_valid exactly 1 cycle after wb, o_busy high meanwhile.
REQ-022 MUL x7 with mdu_busy=1 for 4 cycles -> iss_valid in cycle mdu_busy falls low-to-issue, iss_unit=MDU, no duplicate issue.
REQ-023 CSRRW with x3 busy -> DRAIN until wb x3, then single issue, state RUN, next instruction accepted.
REQ-024 Illegal at address 0x0000_0040 -> trap one cycle, trap_address 0x40, o_busy high until flush, no iss_valid.
REQ-025 Issue ADD x9 and wb x9 same cycle -> bit 9 remains set; flush with bits 5,9 set -> scoreboard zero next cycle.
REQ-026 Async rst_n low mid-DRAIN -> all outputs at reset values immediately, no clock needed.
